// File: rtl/conv_stream_pkg.sv
// Shared definitions for the pixel input side of the stride-2 convolution pipeline.
// Contents:
//   DEF_*            default geometry and widths used as parameter defaults
//   PIXELS_PER_FRAME pixels in one 9x9 feature-map frame
//   pixel_t          signed pixel word
//   streamer_state_t sequencing states of pixel_streamer
package conv_stream_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_IMG_W      = 9;
    localparam int DEF_IMG_H      = 9;
    localparam int DEF_MEM_AW     = 16;
    localparam int DEF_FRAMES_W   = 8;
    localparam int DEF_GAP_CYCLES = 4;

    localparam int PIXELS_PER_FRAME = DEF_IMG_W * DEF_IMG_H;

    typedef logic signed [DEF_DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        GAP,
        FINISH
    } streamer_state_t;

endpackage

// File: rtl/pixel_streamer_if.sv
// Bus bundle between pixel_streamer, the image memory and the conv RAM writer.
// Signals:
//   memEn/memAddr/memData            synchronous-read image memory port
//   outPixel/outValid/outReady       valid/ready pixel stream
//   frameStart/lastPixel             frame markers travelling with outPixel
// Modports:
//   master  streamer side (drives memory request and pixel stream)
//   slave   memory + writer side
interface pixel_streamer_if #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 16
);
    logic                     memEn;
    logic [MEM_AW-1:0]        memAddr;
    logic signed [DATA_W-1:0] memData;
    logic signed [DATA_W-1:0] outPixel;
    logic                     outValid;
    logic                     outReady;
    logic                     frameStart;
    logic                     lastPixel;

    modport master (
        output memEn, memAddr,
        input  memData,
        output outPixel, outValid, frameStart, lastPixel,
        input  outReady
    );

    modport slave (
        input  memEn, memAddr,
        output memData,
        input  outPixel, outValid, frameStart, lastPixel,
        output outReady
    );
endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO holding pixels (plus their frame markers) between the image
// memory read pipeline and the output handshake. The head entry is a register,
// so popData stays stable until pop.
// Ports:
//   clk, reset (sync, active-low)
//   push/pushData   write an entry (accepted when not full, or full with pop)
//   pop             consume the head (ignored when empty)
//   popData         current head entry
//   count           occupancy 0..2
module stream_skid_fifo #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] popData,
    output logic [1:0]   count
);

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != 2'd0);
        // A full FIFO can still take a push when the head leaves this cycle:
        // the write lands in the slot being vacated.
        push_ok  = push && ((count_q != 2'd2) || pop_ok);
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [W-1:0] e_q, e_d;

        always_comb begin
            e_d = e_q;
            if (push_ok && (wr_ptr_q == 1'(gi))) begin
                e_d = pushData;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                e_q <= '0;
            end else begin
                e_q <= e_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign popData = rd_ptr_q ? g_entry[1].e_q : g_entry[0].e_q;
    assign count   = count_q;

endmodule

// File: rtl/pixel_streamer.sv
// Streams stored feature-map frames from a synchronous-read image memory into
// the conv front end's RAM writer, one signed pixel per handshake, with an idle
// gap between frames so the writer can swap ping-pong banks.
// Ports:
//   clk, reset (sync, active-low)
//   start       one-cycle request, accepted only when idle
//   numFrames   frames to send (sampled with start)
//   baseAddr    address of pixel 0 of frame 0 (sampled with start)
//   busy        high from accepted start until the run ends
//   done        one-cycle pulse at the end of a run
//   bus         master side of pixel_streamer_if (memory port + pixel stream)
module pixel_streamer
    import conv_stream_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int MEM_AW     = DEF_MEM_AW,
    parameter int FRAMES_W   = DEF_FRAMES_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [FRAMES_W-1:0] numFrames,
    input  logic [MEM_AW-1:0]   baseAddr,
    output logic                busy,
    output logic                done,
    pixel_streamer_if.master    bus
);

    localparam int PIX     = IMG_W * IMG_H;
    localparam int CNT_W   = $clog2(PIX);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int ENTRY_W = DATA_W + 2;

    streamer_state_t     state_q, state_d;
    logic [FRAMES_W-1:0] num_q, num_d;
    logic [FRAMES_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [MEM_AW-1:0]   frame_base_q, frame_base_d;
    logic [CNT_W-1:0]    fetch_cnt_q, fetch_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    // One memory read in flight, plus the frame markers that belong to it.
    logic                infl_q, infl_d;
    logic                infl_first_q, infl_first_d;
    logic                infl_last_q, infl_last_d;

    logic                mem_en;
    logic [2:0]          occupancy;
    logic                out_valid;
    logic                handshake;
    logic                last_handshake;

    logic                fifo_push;
    logic [ENTRY_W-1:0]  fifo_push_data;
    logic                fifo_pop;
    logic [ENTRY_W-1:0]  fifo_pop_data;
    logic [1:0]          fifo_count;

    stream_skid_fifo #(
        .W(ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .pushData (fifo_push_data),
        .pop      (fifo_pop),
        .popData  (fifo_pop_data),
        .count    (fifo_count)
    );

    // Read data is valid the cycle after memEn; it is pushed that same cycle.
    assign fifo_push      = infl_q;
    assign fifo_push_data = {bus.memData, infl_first_q, infl_last_q};

    assign out_valid      = (fifo_count != 2'd0);
    assign handshake      = out_valid && bus.outReady;
    assign fifo_pop       = handshake;
    assign last_handshake = handshake && fifo_pop_data[0];

    // Entries that will occupy the FIFO next cycle if no read issues now.
    // Counting the departing head keeps full rate while outReady stays high.
    assign occupancy = {1'b0, fifo_count} + {2'b0, infl_q} - {2'b0, fifo_pop};

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        frame_cnt_d  = frame_cnt_q;
        frame_base_d = frame_base_q;
        fetch_cnt_d  = fetch_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        infl_d       = 1'b0;
        infl_first_d = 1'b0;
        infl_last_d  = 1'b0;
        mem_en       = 1'b0;
        busy         = (state_q != IDLE) && (state_q != FINISH);
        done         = (state_q == FINISH);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d        = numFrames;
                    frame_base_d = baseAddr;
                    frame_cnt_d  = '0;
                    fetch_cnt_d  = '0;
                    gap_cnt_d    = '0;
                    state_d      = (numFrames == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (occupancy < 3'd2) begin
                    mem_en       = 1'b1;
                    infl_d       = 1'b1;
                    infl_first_d = (fetch_cnt_q == '0);
                    infl_last_d  = (fetch_cnt_q == CNT_W'(PIX - 1));
                    if (fetch_cnt_q == CNT_W'(PIX - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (last_handshake) begin
                    if (frame_cnt_q == num_q - FRAMES_W'(1)) begin
                        state_d = FINISH;
                    end else begin
                        frame_cnt_d  = frame_cnt_q + FRAMES_W'(1);
                        frame_base_d = frame_base_q + MEM_AW'(PIX);
                        fetch_cnt_d  = '0;
                        gap_cnt_d    = '0;
                        state_d      = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = FETCH;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            num_q        <= '0;
            frame_cnt_q  <= '0;
            frame_base_q <= '0;
            fetch_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            infl_q       <= 1'b0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_base_q <= frame_base_d;
            fetch_cnt_q  <= fetch_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            infl_q       <= infl_d;
            infl_first_q <= infl_first_d;
            infl_last_q  <= infl_last_d;
        end
    end

    assign bus.memEn      = mem_en;
    // Address is parked at 0 whenever no read is issued.
    assign bus.memAddr    = mem_en ? (frame_base_q + MEM_AW'(fetch_cnt_q)) : '0;
    assign bus.outValid   = out_valid;
    assign bus.outPixel   = fifo_pop_data[ENTRY_W-1:2];
    assign bus.frameStart = out_valid && fifo_pop_data[1];
    assign bus.lastPixel  = out_valid && fifo_pop_data[0];

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: image memory model, scoreboard of the
// expected pixel stream built from frame geometry, and several outReady patterns.
module tb_pixel_streamer;
    import conv_stream_pkg::*;

    localparam int PIX = 81;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  numFrames;
    logic [15:0] baseAddr;
    logic        busy;
    logic        done;

    pixel_streamer_if #(.DATA_W(16), .MEM_AW(16)) bus ();

    pixel_streamer #(
        .DATA_W(16), .IMG_W(9), .IMG_H(9), .MEM_AW(16), .FRAMES_W(8), .GAP_CYCLES(GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .numFrames (numFrames),
        .baseAddr  (baseAddr),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Image memory: word = address XOR key, one-cycle read latency.
    logic [15:0] mem_key = 16'h0000;
    always @(posedge clk) begin
        if (bus.memEn) begin
            bus.memData <= bus.memAddr ^ mem_key;
        end
    end

    int     n_checks = 0;
    int     n_fail   = 0;

    pixel_t exp_pix[$];
    bit     exp_fs[$];
    bit     exp_lp[$];
    int     gap_runs[$];

    int     cyc, first_hs_cyc, last_hs_cyc, done_cyc, done_cnt;
    int     fs_cnt, lp_cnt, memen_cnt, rsh, max_rsh, low_run;
    bit     got_first, seen_valid, prev_stall, stall_started, tog;
    int     stall_left, ready_mode;
    pixel_t held_pix;
    logic   held_fs, held_lp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: choose outReady, sample at negedge, score the cycle.
    task automatic tick();
        logic v, hs;
        case (ready_mode)
            1: begin tog = ~tog; bus.outReady = tog; end
            2: bus.outReady = ($urandom_range(0, 3) != 0);
            3: begin
                if (stall_left > 0 && (stall_started || (bus.outValid && bus.outPixel == 16'sd40))) begin
                    stall_started = 1'b1;
                    stall_left--;
                    bus.outReady = 1'b0;
                end else begin
                    bus.outReady = 1'b1;
                end
            end
            default: bus.outReady = 1'b1;
        endcase
        @(negedge clk);
        v  = bus.outValid;
        hs = v && bus.outReady;
        if (prev_stall) begin
            chk("stall_valid", 32'(bus.outValid), 32'd1);
            chk("stall_pixel", 32'(bus.outPixel), 32'(held_pix));
            chk("stall_fs", 32'(bus.frameStart), 32'(held_fs));
            chk("stall_lp", 32'(bus.lastPixel), 32'(held_lp));
        end
        if (hs) begin
            chk("pixel_expected", 32'(exp_pix.size() != 0), 32'd1);
            if (exp_pix.size() != 0) begin
                chk("pixel", 32'(bus.outPixel), 32'(exp_pix.pop_front()));
                chk("frame_start", 32'(bus.frameStart), 32'(exp_fs.pop_front()));
                chk("last_pixel", 32'(bus.lastPixel), 32'(exp_lp.pop_front()));
            end
            if (!got_first) first_hs_cyc = cyc;
            got_first   = 1'b1;
            last_hs_cyc = cyc;
            rsh         = 0;
            if (bus.frameStart) fs_cnt++;
            if (bus.lastPixel) lp_cnt++;
        end else if (bus.memEn) begin
            rsh++;
            if (rsh > max_rsh) max_rsh = rsh;
        end
        if (bus.memEn) memen_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_with_done", 32'(busy), 32'd0);
        end
        prev_stall = v && !bus.outReady;
        held_pix   = bus.outPixel;
        held_fs    = bus.frameStart;
        held_lp    = bus.lastPixel;
        if (v) begin
            if (seen_valid && low_run > 0) gap_runs.push_back(low_run);
            low_run    = 0;
            seen_valid = 1'b1;
        end else if (seen_valid) begin
            low_run++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference model: frame f pixel p lives at base + f*81 + p (mod 2^16).
    task automatic prep(input logic [15:0] base, input int n, input int mode, input logic [15:0] key);
        exp_pix.delete(); exp_fs.delete(); exp_lp.delete(); gap_runs.delete();
        for (int f = 0; f < n; f++) begin
            for (int p = 0; p < PIX; p++) begin
                logic [15:0] a;
                a = 16'(32'(base) + f * PIX + p);
                exp_pix.push_back(pixel_t'(a ^ key));
                exp_fs.push_back(p == 0);
                exp_lp.push_back(p == PIX - 1);
            end
        end
        mem_key = key; ready_mode = mode;
        cyc = 0; first_hs_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_cnt = 0;
        fs_cnt = 0; lp_cnt = 0; memen_cnt = 0; rsh = 0; max_rsh = 0; low_run = 0;
        got_first = 0; seen_valid = 0; prev_stall = 0; stall_started = 0; tog = 0;
        stall_left = 20;
        numFrames = 8'(n);
        baseAddr  = base;
    endtask

    task automatic run(input logic [15:0] base, input int n, input int mode,
                       input logic [15:0] key, input int restart_at);
        int budget;
        prep(base, n, mode, key);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(n > 0));
        budget = n * PIX * 4 + 60;
        while (done_cnt == 0 && cyc < budget) begin
            if (cyc == restart_at) begin
                start = 1'b1; numFrames = 8'd5; baseAddr = 16'd777;
            end
            tick();
            start = 1'b0;
        end
        repeat (3) tick();
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("pixels_left", 32'(exp_pix.size()), 32'd0);
        chk("frame_starts", 32'(fs_cnt), 32'(n));
        chk("last_pixels", 32'(lp_cnt), 32'(n));
        chk("busy_after", 32'(busy), 32'd0);
        chk("mem_reads", 32'(memen_cnt), 32'(n * PIX));
        if (n == 0) begin
            chk("done_latency_empty", 32'(done_cyc), 32'd1);
        end else begin
            chk("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
            chk("reads_beyond_hs_le2", 32'(max_rsh <= 2), 32'd1);
        end
        if (mode == 0 && n > 0) begin
            chk("first_latency", 32'(first_hs_cyc), 32'd3);
            chk("gap_count", 32'(gap_runs.size()), 32'(n - 1));
            foreach (gap_runs[i]) chk("gap_len", 32'(gap_runs[i]), 32'(GAP + 2));
        end
        if (mode == 3) chk("stall_happened", 32'(stall_left), 32'd0);
        $display("run base=%0d frames=%0d ready_mode=%0d cycles=%0d", base, n, mode, cyc);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; numFrames = 8'd0; baseAddr = 16'd0;
        bus.outReady = 1'b0; ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_memEn", 32'(bus.memEn), 32'd0);
        chk("rst_memAddr", 32'(bus.memAddr), 32'd0);
        chk("rst_outPixel", 32'(bus.outPixel), 32'd0);
        chk("rst_outValid", 32'(bus.outValid), 32'd0);
        chk("rst_frameStart", 32'(bus.frameStart), 32'd0);
        chk("rst_lastPixel", 32'(bus.lastPixel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run(16'd0, 1, 0, 16'h0000, -1);            // single frame, always ready
        run(16'd0, 1, 1, 16'h0000, -1);            // toggling ready
        run(16'd0, 1, 3, 16'h0000, -1);            // 20-cycle stall at pixel 40
        run(16'd100, 2, 0, 16'h0000, -1);          // two frames with gap
        run(16'd0, 0, 0, 16'h0000, -1);            // empty run
        run(16'd0, 1, 0, 16'h0000, 10);            // start while busy is ignored

        // Reset in the middle of a frame, then a clean restart.
        prep(16'd0, 1, 0, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!(bus.outValid && bus.outPixel == 16'sd30) && cyc < 200) tick();
        chk("reached_pixel30", 32'(bus.outPixel), 32'd30);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_memEn", 32'(bus.memEn), 32'd0);
        chk("mid_rst_memAddr", 32'(bus.memAddr), 32'd0);
        chk("mid_rst_outPixel", 32'(bus.outPixel), 32'd0);
        chk("mid_rst_outValid", 32'(bus.outValid), 32'd0);
        chk("mid_rst_frameStart", 32'(bus.frameStart), 32'd0);
        chk("mid_rst_lastPixel", 32'(bus.lastPixel), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        $display("reset applied at pixel 30");
        run(16'd0, 1, 0, 16'h0000, -1);

        // Randomized content and ready pattern, including address wrap.
        run(16'hFFC0, 2, 2, 16'($urandom), -1);
        run(16'($urandom), 3, 2, 16'($urandom), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
Transmit side of the pixel input interface of the stride-2 convolution pipeline. Fetches stored 9x9 feature-map frames from a synchronous-read image memory and streams them one signed 16-bit pixel at a time into the conv front end's RAM writer. Uses a valid/ready handshake and inserts an inter-frame gap so the writer can swap ping-pong banks (0-80 / 81-161). Replaces the free-running constant pixel drive used today.

Parameters:
DATA_W, 16, pixel width (signed)
IMG_W, 9, frame width in pixels
IMG_H, 9, frame height in pixels
MEM_AW, 16, image memory address width
FRAMES_W, 8, width of frame-count input
GAP_CYCLES, 4, idle cycles between the last handshake of a frame and the next frame's first fetch (>=1)

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous, active-low reset (reset==0 clears state on the clk rising edge)
start  in  1  one-cycle pulse; begins a run when idle
numFrames  in  FRAMES_W  frames to send; sampled when start is accepted
baseAddr  in  MEM_AW  memory address of pixel 0 of frame 0; sampled with start
memEn  out  1  image memory read enable
memAddr  out  MEM_AW  image memory read address
memData  in  DATA_W  read data, valid exactly 1 cycle after memEn
outPixel  out  DATA_W  signed pixel to conv RAM writer
outValid  out  1  outPixel valid
outReady  in  1  writer can accept; transfer when outValid && outReady
frameStart  out  1  high with pixel 0 of each frame (qualified by outValid)
lastPixel  out  1  high with pixel IMG_W*IMG_H-1 of each frame
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset values: memEn=0, memAddr=0, outPixel=0, outValid=0, frameStart=0, lastPixel=0, busy=0, done=0, FSM=IDLE, all counters 0, buffer empty.
- Reset mid-run drops all buffered and in-flight data. memData returned after reset is ignored.
- FSM states: IDLE, FETCH, DRAIN, GAP, FINISH.
- IDLE: on start=1, latch numFrames and baseAddr, then go to FETCH. If numFrames==0, go directly to FINISH instead.
- FETCH: memAddr = baseAddr + frameCnt*IMG_W*IMG_H + fetchCnt. Issue memEn only when (buffered + in-flight) < 2.
  - After fetchCnt reaches IMG_W*IMG_H-1 and that read issues, go to DRAIN.
- DRAIN: no reads. On the handshake of the frame's last pixel:
  - if frameCnt==numFrames-1, go to FINISH;
  - otherwise increment frameCnt, clear fetchCnt, and go to GAP.
- GAP: count GAP_CYCLES cycles, then go to FETCH.
- FINISH: done=1 for one cycle, busy=0, then go to IDLE.
- start is ignored while busy.
- Latency: start sampled at edge 0 -> memEn in cycle 1 -> data captured at end of cycle 2 -> outValid in cycle 3.
- Throughput: 1 pixel/cycle while outReady=1.
- Output buffer: 2-entry skid FIFO.
  - outPixel, frameStart and lastPixel are the FIFO head and stay stable while outValid && !outReady.
  - No drop or duplication under any outReady pattern.
- Between frames, with outReady=1, outValid is low for exactly GAP_CYCLES+2 cycles.
- Address arithmetic wraps modulo 2^MEM_AW. No overflow detection.
- Simultaneous FIFO push and pop is allowed at every occupancy.

Decomposition:
- Package conv_stream_pkg:
  - typedef pixel_t (logic signed [DATA_W-1:0]);
  - PIXELS_PER_FRAME = IMG_W*IMG_H (81);
  - typedef enum streamer_state_t {IDLE, FETCH, DRAIN, GAP, FINISH}.
- Sub-module stream_skid_fifo: 2-entry FIFO carrying {pixel, frameStart, lastPixel}.
  - Ports: push, pushData, pop, popData, count.
  - The read-issue throttle uses count plus the in-flight flag.

Test Plan:
- Memory word = address, baseAddr=0, numFrames=1, outReady=1 -> 81 consecutive pixels 0..80 starting 3 cycles after start; frameStart with 0, lastPixel with 80; done 1 cycle after the handshake of 80, busy low with done.
- Same setup with outReady toggling 1/0 every cycle -> values 0..80 in order, no drop or duplicate; outPixel stable during every stall.
- outReady=0 for 20 cycles when outPixel=40 -> outPixel held at 40, at most 2 reads beyond the last handshake, resumes with 41.
- numFrames=2, GAP_CYCLES=4, baseAddr=100, outReady=1 -> frame 0 = 100..180, frame 1 = 181..261, outValid low exactly 6 cycles between the frames, two frameStart and two lastPixel pulses, one done.
- reset=0 for one cycle at pixel 30 -> all outputs 0 next cycle. A new start gives pixel 0 (baseAddr) again 3 cycles later, with no stale data.
- numFrames=0 -> done pulses the cycle after start and memEn never asserts. A second start while busy in a normal run is ignored (pixel count stays 81).
